// File: rtl/pipe_stage_fifo_pkg.sv
// Shared definitions for the inter-stage pipeline buffers: default payload
// widths per stage boundary and the sizing helpers used for counters and
// pointers.
package pipe_stage_fifo_pkg;

  // Default payload carried between PreIF/IF and IF/ID: pc (32) + inst (32).
  localparam int PcInstBusWidth = 64;

  // Ceiling log2; clog2(1) = 0.
  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r++;
      v = v >>> 1;
    end
    return r;
  endfunction

  // Pointer width never drops below one bit, even for a single entry.
  function automatic int ptr_width(input int depth);
    return (clog2(depth) < 1) ? 1 : clog2(depth);
  endfunction

endpackage

// File: rtl/pipe_stage_fifo_if.sv
// valid/allowin handshake bundle between two pipeline stages, including the
// redirect flush. The buffer takes the slave side; the neighbouring stages
// together form the master side.
interface pipe_stage_fifo_if
  import pipe_stage_fifo_pkg::*;
#(
  parameter int DATA_W = PcInstBusWidth
);

  logic              up_valid_i;
  logic              up_allowin_o;
  logic [DATA_W-1:0] up_data_i;
  logic              flush_i;
  logic              down_valid_o;
  logic              down_allowin_i;
  logic [DATA_W-1:0] down_data_o;

  modport master (
    output up_valid_i, up_data_i, flush_i, down_allowin_i,
    input  up_allowin_o, down_valid_o, down_data_o
  );

  modport slave (
    input  up_valid_i, up_data_i, flush_i, down_allowin_i,
    output up_allowin_o, down_valid_o, down_data_o
  );

endinterface

// File: rtl/pipe_stage_fifo_ctrl.sv
// Occupancy and pointer control for pipe_stage_fifo: push/pop/flush decode,
// the allowin equation, read/write pointers and the entry count.
module pipe_stage_fifo_ctrl
  import pipe_stage_fifo_pkg::*;
#(
  parameter  int DEPTH      = 1,
  parameter  int PASS_READY = 1,
  localparam int PTR_W      = ptr_width(DEPTH),
  localparam int OCC_W      = clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             up_valid,
  input  logic             flush,
  input  logic             down_allowin,
  output logic             up_allowin,
  output logic             down_valid,
  output logic             push,
  output logic             pop,
  output logic [PTR_W-1:0] wr_ptr,
  output logic [PTR_W-1:0] rd_ptr,
  output logic [OCC_W-1:0] count
);

  localparam logic [OCC_W-1:0] FULL_CNT = OCC_W'(DEPTH);
  localparam logic             PASS     = (PASS_READY != 0);

  // Handshake decode. With PASS set, a full buffer still accepts when the
  // head leaves this cycle; this is the only down_allowin -> up_allowin path.
  // Flush kills both transfers but does not alter what allowin shows.
  always_comb begin
    down_valid = (count != '0);
    up_allowin = (count < FULL_CNT) | (PASS & down_allowin & down_valid);
    push       = up_valid & up_allowin & ~flush;
    pop        = down_valid & down_allowin & ~flush;
  end

  // Entry count: flush empties, simultaneous push and pop leave it unchanged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (flush) begin
      count <= '0;
    end else if (push && !pop) begin
      count <= count + OCC_W'(1);
    end else if (pop && !push) begin
      count <= count - OCC_W'(1);
    end
  end

  if (DEPTH == 1) begin : g_single
    // A single entry needs no addressing.
    assign wr_ptr = '0;
    assign rd_ptr = '0;
  end else begin : g_multi
    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + PTR_W'(1);
        if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      end
    end
  end

endmodule

// File: rtl/pipe_stage_fifo.sv
// Inter-stage pipeline buffer. DEPTH entries of DATA_W payload under the
// valid/allowin handshake, with redirect flush, occupancy output and a
// saturating back-pressure counter. DEPTH=1, PASS_READY=1 behaves exactly
// like a plain stage register.
module pipe_stage_fifo
  import pipe_stage_fifo_pkg::*;
#(
  parameter  int DATA_W     = PcInstBusWidth,
  parameter  int DEPTH      = 1,
  parameter  int PASS_READY = 1,
  parameter  int CNT_W      = 16,
  localparam int OCC_W      = clog2(DEPTH) + 1,
  localparam int PTR_W      = ptr_width(DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  pipe_stage_fifo_if.slave     bus,
  output logic [OCC_W-1:0]     count_o,
  output logic [CNT_W-1:0]     stall_cnt_o
);

  logic              up_allowin;
  logic              down_valid;
  logic              push;
  logic              pop;
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [OCC_W-1:0]  count;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [CNT_W-1:0]  stall_cnt;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  pipe_stage_fifo_ctrl #(
    .DEPTH      (DEPTH),
    .PASS_READY (PASS_READY)
  ) u_ctrl (
    .clk          (clk),
    .rst_n        (rst_n),
    .up_valid     (bus.up_valid_i),
    .flush        (bus.flush_i),
    .down_allowin (bus.down_allowin_i),
    .up_allowin   (up_allowin),
    .down_valid   (down_valid),
    .push         (push),
    .pop          (pop),
    .wr_ptr       (wr_ptr),
    .rd_ptr       (rd_ptr),
    .count        (count)
  );

  // Storage: cleared on reset so an idle buffer presents zero; entries left
  // behind by a flush or a pop are kept but no longer marked valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (push) begin
      mem[wr_ptr] <= bus.up_data_i;
    end
  end

  // Back-pressure counter: cycles where upstream waits, saturating, and
  // deliberately kept across flushes so redirects do not hide stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (bus.up_valid_i && !up_allowin) begin
      stall_cnt <= sat_inc(stall_cnt);
    end
  end

  // Head is read straight from storage: no output register, no bypass.
  always_comb begin
    bus.up_allowin_o = up_allowin;
    bus.down_valid_o = down_valid;
    bus.down_data_o  = mem[rd_ptr];
    count_o          = count;
    stall_cnt_o      = stall_cnt;
  end

endmodule

// File: doc/pipe_stage_fifo.md
# pipe_stage_fifo

Parametrised inter-stage pipeline buffer that replaces the fixed single-entry stage registers between PreIF/IF, IF/ID, ID/EX, EX/MEM and MEM/WB. It carries one concatenated payload (pc/inst bus plus stage bus) under the existing valid/allowin handshake. It also adds:
- configurable depth, for stage decoupling;
- a synchronous flush, for branch and exception redirect;
- an occupancy output;
- a saturating back-pressure counter, for performance debug.

With DEPTH=1 and PASS_READY=1 it is cycle-equivalent to the current stage registers.

## Interface
Parameters:
- DATA_W, 64: payload width in bits (pc 32 + inst 32 by default; stages widen to include their bus).
- DEPTH, 1: entries; power of two, 1..16.
- PASS_READY, 1: 1 = up_allowin_o may assert when full if downstream pops this cycle; 0 = up_allowin_o depends on occupancy only.
- CNT_W, 16: width of stall_cnt_o.

Ports:
- clk, in, 1: single clock, rising edge.
- rst_n, in, 1: asynchronous active-low reset.
- up_valid_i, in, 1: upstream has a valid item (x_to_y_valid).
- up_allowin_o, out, 1: buffer can accept this cycle.
- up_data_i, in, DATA_W: upstream payload.
- flush_i, in, 1: discard all held entries and any push this cycle.
- down_valid_o, out, 1: head entry valid (y_valid).
- down_allowin_i, in, 1: downstream accepts the head this cycle.
- down_data_o, out, DATA_W: head payload.
- count_o, out, clog2(DEPTH)+1: current occupancy.
- stall_cnt_o, out, CNT_W: cycles with up_valid_i=1 and up_allowin_o=0, saturating.

## Operation
Handshake and pointers:
- push = up_valid_i & up_allowin_o & ~flush_i.
- pop = down_valid_o & down_allowin_i & ~flush_i.
- up_allowin_o = (count < DEPTH) | (PASS_READY & down_allowin_i & down_valid_o).
- down_valid_o = (count != 0); down_data_o = mem[rd_ptr], driven directly from storage with no output register.
- Pointer width is max(1, clog2(DEPTH)); pointers wrap modulo DEPTH. For DEPTH=1 both pointers are constant 0.

Per-cycle update:
- push only: write mem[wr_ptr], wr_ptr+1, count+1.
- pop only: rd_ptr+1, count-1.
- push and pop together: both pointers advance, count unchanged. This is legal when full only if PASS_READY=1, and legal when empty never, because pop needs down_valid_o.
- flush_i: count, rd_ptr and wr_ptr all go to 0 next cycle. Memory contents are kept but are invalid. Flush takes priority over a simultaneous push or pop, so neither counts as a transfer.

stall_cnt_o:
- Increments when up_valid_i & ~up_allowin_o, saturating at all-ones.
- Is not cleared by flush_i.

Illegal states:
- No overflow is possible by construction.
- Any push while count==DEPTH and no pop is a design error; the bench asserts it never happens.

## Timing
- Reset values (async, while rst_n=0): count_o=0, down_valid_o=0, pointers 0, all mem entries 0 so down_data_o=0, stall_cnt_o=0, up_allowin_o=1.
- Latency: an item pushed in cycle N is visible on down_valid_o/down_data_o in cycle N+1. There is no same-cycle bypass.
- Throughput: 1 item/cycle sustained for any DEPTH with PASS_READY=1. With PASS_READY=0 and DEPTH=1, 1 item per 2 cycles.
- Combinational paths:
  - PASS_READY=1: down_allowin_i to up_allowin_o only.
  - PASS_READY=0: none; all outputs are from registers.
  - Never a path from up_valid_i to down_valid_o.
- Flush in cycle N: down_valid_o=0 from cycle N+1. A new push is accepted from cycle N+1.
- Reset deasserting mid-operation: the FIFO starts empty on the first clk edge after release.

## Structure
- Shared package (pipe_pkg): DATA_W defaults per stage boundary (PcInstBusWidth and the stage bus widths already in DefineModuleBus.h, mirrored as localparams), and a clog2 function.
- One sub-module, pipe_fifo_ctrl: pointers, count, push/pop/flush decode and the allowin equation. The storage array and the stall counter stay in the top.
- The top pipeline instantiates pipe_stage_fifo at each boundary. Flush inputs are wired from the existing redirect signal (id_to_preif bus bit 32 for IF/ID).

## Test plan
- Reset then idle: rst_n low 3 cycles, then high → count_o=0, down_valid_o=0, down_data_o=0, up_allowin_o=1, stall_cnt_o=0.
- DEPTH=1, PASS_READY=1, down_allowin_i=1, push 0x1C000000_02800413 every cycle for 8 cycles → each item appears 1 cycle later; 8 pops; count_o stays 1; stall_cnt_o=0.
- DEPTH=4, down_allowin_i=0, push values 1..6 → values 1..4 accepted; up_allowin_o=0 from the cycle count_o=4; stall_cnt_o=2. Then down_allowin_i=1 → output order 1,2,3,4 and pointers wrap cleanly.
- DEPTH=4, PASS_READY=0, full, down_allowin_i=1 and up_valid_i=1 → up_allowin_o=0 that cycle; count_o drops to 3; the next push is accepted the cycle after.
- DEPTH=4 holding 3 entries, flush_i=1 together with up_valid_i=1 and down_allowin_i=1 → next cycle count_o=0, down_valid_o=0, the flushed push is not stored; a push in the following cycle emerges as the sole item.
- CNT_W=4, up_valid_i=1, down_allowin_i=0 for 40 cycles on DEPTH=2 → stall_cnt_o saturates at 15; assertion: no push while full without a pop.
